// File: rtl/opponent_rx_decoder.sv
// Opponent frame decoder: validates 44-bit frames, holds last good state, debounces remote reset, tracks link timeout.
// Optional saturating good/bad frame statistics enabled with `define OPP_RX_STATS_EN.
module opponent_rx_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter int unsigned RESET_CONFIRM  = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        axiov_in,
    input  logic [43:0] axiod_in,
    output logic [10:0] opp_x_out,
    output logic [10:0] opp_y_out,
    output logic [8:0]  opp_dir_out,
    output logic [2:0]  opp_game_out,
    output logic        opp_update_out,
    output logic        opp_reset_req_out,
    output logic        link_up_out,
    output logic [15:0] good_cnt_out,
    output logic [15:0] bad_cnt_out
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW = $clog2(RESET_CONFIRM + 1);
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CONFIRM = CW'(RESET_CONFIRM);

    typedef struct packed {
        logic [10:0] x;
        logic        rsv32;
        logic [10:0] y;
        logic        rsv20;
        logic [8:0]  dir;
        logic [2:0]  rsv10_8;
        logic [2:0]  game;
        logic        rsv4;
        logic        rst;
        logic [2:0]  rsv2_0;
    } frame_t;

    typedef enum logic {ARMED, FIRED} state_t;

    frame_t          frame;
    logic            frame_ok_c;
    logic            good_c;
    state_t          state, state_nxt;
    logic [CW-1:0]   confirm, confirm_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [10:0]     x_nxt, y_nxt;
    logic [8:0]      dir_nxt;
    logic [2:0]      game_nxt;
    logic            update_nxt, req_nxt, link_nxt;

    assign frame = frame_t'(axiod_in);

    // Reserved bits clear, direction in range, and not an all-zero idle word
    assign frame_ok_c = !frame.rsv32 && !frame.rsv20 && (frame.rsv10_8 == 3'b000)
                      && !frame.rsv4 && (frame.rsv2_0 == 3'b000)
                      && (frame.dir < 9'd360) && (|axiod_in);
    assign good_c = axiov_in && frame_ok_c;

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        confirm_nxt = confirm;
        timer_nxt   = (timer == TMAX) ? timer : timer + TW'(1);
        x_nxt       = opp_x_out;
        y_nxt       = opp_y_out;
        dir_nxt     = opp_dir_out;
        game_nxt    = opp_game_out;
        update_nxt  = 1'b0;
        req_nxt     = 1'b0;
        link_nxt    = link_up_out;

        if (good_c) begin
            x_nxt      = frame.x;
            y_nxt      = frame.y;
            dir_nxt    = frame.dir;
            game_nxt   = frame.game;
            update_nxt = 1'b1;
            timer_nxt  = '0;
            link_nxt   = 1'b1;
            case (state)
                ARMED: begin
                    if (frame.rst) begin
                        confirm_nxt = confirm + CW'(1);
                        if (confirm + CW'(1) == CONFIRM) begin
                            req_nxt   = 1'b1;
                            state_nxt = FIRED;
                        end
                    end else begin
                        confirm_nxt = '0;
                    end
                end
                FIRED: begin
                    if (!frame.rst) begin
                        confirm_nxt = '0;
                        state_nxt   = ARMED;
                    end
                end
                default: state_nxt = ARMED;
            endcase
        end else if (timer_nxt == TMAX) begin
            link_nxt    = 1'b0;
            confirm_nxt = '0;
            state_nxt   = ARMED;
        end
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state             <= ARMED;
            confirm           <= '0;
            timer             <= '0;
            opp_x_out         <= '0;
            opp_y_out         <= '0;
            opp_dir_out       <= '0;
            opp_game_out      <= '0;
            opp_update_out    <= 1'b0;
            opp_reset_req_out <= 1'b0;
            link_up_out       <= 1'b0;
        end else begin
            state             <= state_nxt;
            confirm           <= confirm_nxt;
            timer             <= timer_nxt;
            opp_x_out         <= x_nxt;
            opp_y_out         <= y_nxt;
            opp_dir_out       <= dir_nxt;
            opp_game_out      <= game_nxt;
            opp_update_out    <= update_nxt;
            opp_reset_req_out <= req_nxt;
            link_up_out       <= link_nxt;
        end
    end

`ifdef OPP_RX_STATS_EN
    logic bad_c;
    assign bad_c = axiov_in && !frame_ok_c;

    // Saturating frame statistics
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            good_cnt_out <= '0;
            bad_cnt_out  <= '0;
        end else begin
            if (good_c && (good_cnt_out != 16'hFFFF)) good_cnt_out <= good_cnt_out + 16'd1;
            if (bad_c && (bad_cnt_out != 16'hFFFF))   bad_cnt_out  <= bad_cnt_out + 16'd1;
        end
    end
`else
    assign good_cnt_out = 16'h0000;
    assign bad_cnt_out  = 16'h0000;
`endif

endmodule
